// File: rtl/idli_pkg.sv
// Shared idli types: decoded instruction layout plus the nibble-encoder format,
// class and state types.
package idli_pkg;

    typedef struct packed {
        logic [1:0] p;
        logic [1:0] q;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] c;
    } instr_t;

    typedef enum logic [1:0] {
        CLS_00 = 2'b00,
        CLS_01 = 2'b01,
        CLS_10 = 2'b10,
        CLS_11 = 2'b11
    } enc_cls_t;

    // Bit layout matches the raw 5-bit op: sub = op[4:2], cls = op[1:0].
    typedef struct packed {
        logic [2:0] sub;
        enc_cls_t   cls;
    } enc_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4
    } enc_state_t;

    localparam int ENC_NIBS = 4;

    // Nibble index currently on the output; IDLE maps to 0 but is masked.
    function automatic logic [1:0] enc_nib_idx(enc_state_t st);
        logic [1:0] idx;
        idx = 2'd0;
        case (st)
            S1:      idx = 2'd1;
            S2:      idx = 2'd2;
            S3:      idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/idli_encode_m_if.sv
// Instruction-in / nibble-out bundle between the instruction source and the encoder.
interface idli_encode_if;
    import idli_pkg::*;

    instr_t     i_enc_instr;
    logic [4:0] i_enc_op;
    logic       i_enc_vld;
    logic       o_enc_rdy;
    logic [3:0] o_enc_nib;
    logic       o_enc_nib_vld;

    modport master (
        output i_enc_instr, i_enc_op, i_enc_vld,
        input  o_enc_rdy, o_enc_nib, o_enc_nib_vld
    );

    modport slave (
        input  i_enc_instr, i_enc_op, i_enc_vld,
        output o_enc_rdy, o_enc_nib, o_enc_nib_vld
    );

endinterface

// File: rtl/idli_encode_m_nib.sv
// Pure combinational nibble builder: picks nibble idx of the 4-nibble stream for
// one instruction/format pair.
module idli_encode_nib_m
    import idli_pkg::*;
(
    input  instr_t     instr,
    input  enc_op_t    op,
    input  logic [1:0] idx,
    output logic [3:0] nib
);

    logic cls01_hi;
    logic cls10_sub11;

    // cls 01 with op[3] set carries no a/b fields; cls 10 sub 11x carries no c.
    assign cls01_hi    = (op.cls == CLS_01) && op.sub[1];
    assign cls10_sub11 = (op.cls == CLS_10) && (op.sub[2:1] == 2'b11);

    always_comb begin
        nib = 4'b0000;
        case (idx)
            2'd0: nib = {instr.p, op.cls};
            2'd1: begin
                case (op.cls)
                    CLS_00:  nib = {op.sub[2], instr.q, instr.a[2]};
                    CLS_01:  nib = {op.sub[1], instr.q, op.sub[0]};
                    default: nib = {op.sub, instr.a[2]};
                endcase
            end
            2'd2: nib = cls01_hi ? 4'b0000 : {instr.a[1:0], instr.b[2:1]};
            default: begin
                if (cls01_hi)
                    nib = {1'b0, instr.c};
                else if (cls10_sub11)
                    nib = {instr.b[0], 3'b000};
                else
                    nib = {instr.b[0], instr.c};
            end
        endcase
    end

endmodule

// File: rtl/idli_encode_m.sv
// Serialises one decoded instruction into four consecutive nibbles for the
// nibble decoder; accepts the next instruction while the last nibble is out.
module idli_encode_m
    import idli_pkg::*;
(
    input  logic         i_enc_gck,
    input  logic         i_enc_rst,
    idli_encode_if.slave enc
);

    enc_state_t state, state_nxt;
    instr_t     hold_instr;
    enc_op_t    hold_op;
    logic       accept;
    logic [3:0] nib_w;

    assign enc.o_enc_rdy = (state == IDLE) || (state == S3);
    assign accept        = enc.i_enc_vld && enc.o_enc_rdy;

    always_ff @(posedge i_enc_gck or posedge i_enc_rst) begin
        if (i_enc_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    // Holding registers are only observed outside IDLE, so they carry no reset.
    always_ff @(posedge i_enc_gck) begin
        if (accept) begin
            hold_instr <= enc.i_enc_instr;
            hold_op    <= enc_op_t'(enc.i_enc_op);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? S0 : IDLE;
            S0:      state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = S3;
            S3:      state_nxt = accept ? S0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    idli_encode_nib_m u_nib (
        .instr (hold_instr),
        .op    (hold_op),
        .idx   (enc_nib_idx(state)),
        .nib   (nib_w)
    );

    assign enc.o_enc_nib_vld = (state != IDLE);
    assign enc.o_enc_nib     = (state == IDLE) ? 4'b0000 : nib_w;

endmodule

// File: tb/tb_idli_encode_m.sv
// Bench for idli_encode_m: directed format vectors, back-to-back, async reset,
// and a random loopback through a nibble-stream decoder model.
module tb_idli_encode_m;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    idli_encode_if ifc ();

    idli_encode_m dut (
        .i_enc_gck (clk),
        .i_enc_rst (rst),
        .enc       (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Nibble k of an instruction, straight from the format table.
    function automatic logic [3:0] ref_nib(logic [12:0] ins, logic [4:0] op, int k);
        logic [1:0] p, q, cls;
        logic [2:0] a, b, c, sub;
        p = ins[12:11]; q = ins[10:9]; a = ins[8:6]; b = ins[5:3]; c = ins[2:0];
        cls = op[1:0]; sub = op[4:2];
        if (k == 0) return {p, cls};
        if (k == 1) begin
            if (cls == 2'b00) return {op[4], q, a[2]};
            if (cls == 2'b01) return {op[3], q, op[2]};
            return {sub, a[2]};
        end
        if (k == 2) return (cls == 2'b01 && op[3]) ? 4'b0000 : {a[1:0], b[2:1]};
        if (cls == 2'b01 && op[3]) return {1'b0, c};
        if (cls == 2'b10 && sub[2:1] == 2'b11) return {b[0], 3'b000};
        return {b[0], c};
    endfunction

    task automatic drive(logic v, logic [12:0] ins, logic [4:0] op);
        ifc.i_enc_vld   = v;
        ifc.i_enc_instr = ins;
        ifc.i_enc_op    = op;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 13'd0, 5'd0);
        #12;
        n_vec++;
        if (ifc.o_enc_rdy !== 1'b1 || ifc.o_enc_nib_vld !== 1'b0 || ifc.o_enc_nib !== 4'b0000) begin
            n_err++;
            $display("FAIL reset: rdy=%b vld=%b nib=%b want rdy=1 vld=0 nib=0000",
                     ifc.o_enc_rdy, ifc.o_enc_nib_vld, ifc.o_enc_nib);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_formats();
        logic [12:0] ti [3];
        logic [4:0]  to [3];
        logic [3:0]  tn [3][4];
        ti[0] = {2'b10, 2'b01, 3'b101, 3'b011, 3'b110}; to[0] = 5'b00000;
        tn[0] = '{4'b1000, 4'b0011, 4'b0101, 4'b1110};
        ti[1] = {2'b01, 2'b11, 3'b000, 3'b000, 3'b101}; to[1] = 5'b01001;
        tn[1] = '{4'b0101, 4'b1110, 4'b0000, 4'b0101};
        ti[2] = {2'b00, 2'b00, 3'b111, 3'b101, 3'b000}; to[2] = 5'b11010;
        tn[2] = '{4'b0010, 4'b1101, 4'b1110, 4'b1000};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_vec++;
            if (ifc.o_enc_rdy !== 1'b1 || ifc.o_enc_nib_vld !== 1'b0) begin
                n_err++;
                $display("FAIL fmt%0d idle: rdy=%b vld=%b want 1/0", t, ifc.o_enc_rdy, ifc.o_enc_nib_vld);
            end
            drive(1'b1, ti[t], to[t]);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                drive(1'b0, 13'h1fff, 5'h1f);
                n_vec++;
                if (ifc.o_enc_nib !== tn[t][k] || ifc.o_enc_nib_vld !== 1'b1 ||
                    ifc.o_enc_rdy !== (k == 3)) begin
                    n_err++;
                    $display("FAIL fmt%0d n%0d: nib=%b vld=%b rdy=%b want nib=%b vld=1 rdy=%b",
                             t, k, ifc.o_enc_nib, ifc.o_enc_nib_vld, ifc.o_enc_rdy, tn[t][k], k == 3);
                end
            end
        end
        @(negedge clk);
        n_vec++;
        if (ifc.o_enc_nib_vld !== 1'b0 || ifc.o_enc_nib !== 4'b0000) begin
            n_err++;
            $display("FAIL fmt tail: vld=%b nib=%b want 0/0000", ifc.o_enc_nib_vld, ifc.o_enc_nib);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] ia, ib;
        logic [4:0]  oa, ob;
        ia = 13'h0b5e; oa = 5'b00011;
        ib = 13'h1a27; ob = 5'b10110;
        @(negedge clk);
        drive(1'b1, ia, oa);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            // A's S3 is the only slot where B gets captured; garbage elsewhere.
            if (k == 3)      drive(1'b1, ib, ob);
            else if (k < 3)  drive(1'b1, ~ib, ~ob);
            else             drive(1'b0, 13'd0, 5'd0);
            n_vec++;
            if (ifc.o_enc_nib_vld !== 1'b1 || ifc.o_enc_rdy !== (k % 4 == 3) ||
                ifc.o_enc_nib !== ref_nib(k < 4 ? ia : ib, k < 4 ? oa : ob, k % 4)) begin
                n_err++;
                $display("FAIL b2b n%0d: nib=%b vld=%b rdy=%b want nib=%b vld=1 rdy=%b", k,
                         ifc.o_enc_nib, ifc.o_enc_nib_vld, ifc.o_enc_rdy,
                         ref_nib(k < 4 ? ia : ib, k < 4 ? oa : ob, k % 4), k % 4 == 3);
            end
        end
        @(negedge clk);
        n_vec++;
        if (ifc.o_enc_nib_vld !== 1'b0) begin
            n_err++;
            $display("FAIL b2b tail: vld=%b want 0", ifc.o_enc_nib_vld);
        end
    endtask

    task automatic test_mid_reset();
        logic [12:0] ins;
        logic [4:0]  op;
        ins = 13'h15c3; op = 5'b00100;
        @(negedge clk);
        drive(1'b1, ins, op);
        @(negedge clk);
        drive(1'b0, 13'd0, 5'd0);
        @(negedge clk);
        n_vec++;
        if (ifc.o_enc_nib !== ref_nib(ins, op, 1)) begin
            n_err++;
            $display("FAIL rst pre: nib=%b want %b", ifc.o_enc_nib, ref_nib(ins, op, 1));
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (ifc.o_enc_nib_vld !== 1'b0 || ifc.o_enc_nib !== 4'b0000 || ifc.o_enc_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL rst async: vld=%b nib=%b rdy=%b want 0/0000/1",
                     ifc.o_enc_nib_vld, ifc.o_enc_nib, ifc.o_enc_rdy);
        end
        #1 rst = 1'b0;
        ins = 13'h0e71; op = 5'b11111;
        @(negedge clk);
        drive(1'b1, ins, op);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 13'd0, 5'd0);
            n_vec++;
            if (ifc.o_enc_nib !== ref_nib(ins, op, k) || ifc.o_enc_nib_vld !== 1'b1) begin
                n_err++;
                $display("FAIL rst post n%0d: nib=%b vld=%b want %b/1", k,
                         ifc.o_enc_nib, ifc.o_enc_nib_vld, ref_nib(ins, op, k));
            end
        end
    endtask

    // Queue model: expq holds nibbles still owed; accq holds accepted pairs for
    // loopback decoding of the observed stream.
    task automatic test_random();
        logic [3:0]  expq [$];
        logic [17:0] accq [$];
        logic [3:0]  got [4];
        logic [3:0]  en;
        logic [17:0] acc;
        logic [12:0] ins;
        logic [4:0]  op;
        logic [1:0]  cls;
        logic        v, rdy_m;
        int ngot = 0, nacc = 0, cyc = 0;
        while ((nacc < 1000 || expq.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            en    = (expq.size() != 0) ? expq[0] : 4'b0000;
            rdy_m = (expq.size() <= 1);
            n_vec++;
            if (ifc.o_enc_nib_vld !== (expq.size() != 0) || ifc.o_enc_nib !== en ||
                ifc.o_enc_rdy !== rdy_m) begin
                n_err++;
                $display("FAIL rand cyc%0d: vld=%b nib=%b rdy=%b want %b/%b/%b", cyc,
                         ifc.o_enc_nib_vld, ifc.o_enc_nib, ifc.o_enc_rdy,
                         expq.size() != 0, en, rdy_m);
            end
            if (ifc.o_enc_nib_vld === 1'b1) begin
                got[ngot] = ifc.o_enc_nib;
                ngot++;
                if (ngot == 4) begin
                    ngot = 0;
                    acc  = (accq.size() != 0) ? accq.pop_front() : 18'h3ffff;
                    ins  = acc[17:5];
                    op   = acc[4:0];
                    cls  = got[0][1:0];
                    n_vec++;
                    if (acc[17] === 1'b1 && acc == 18'h3ffff) begin
                        n_err++;
                        $display("FAIL loop: decoded instruction with none accepted");
                    end else if (got[0][3:2] !== ins[12:11] || cls !== op[1:0] ||
                        ((cls == 2'b00 || cls == 2'b01) && got[1][2:1] !== ins[10:9]) ||
                        (cls != 2'b01 && {got[1][0], got[2][3:2]} !== ins[8:6]) ||
                        (!(cls == 2'b01 && op[3]) && {got[2][1:0], got[3][3]} !== ins[5:3]) ||
                        (!(cls == 2'b10 && op[4:3] == 2'b11) && got[3][2:0] !== ins[2:0])) begin
                        n_err++;
                        $display("FAIL loop: nibs=%h%h%h%h want instr=%b op=%b",
                                 got[0], got[1], got[2], got[3], ins, op);
                    end
                end
            end
            if (expq.size() != 0) void'(expq.pop_front());
            v   = (nacc < 1000) && ($urandom_range(0, 3) != 0);
            ins = 13'($urandom);
            op  = 5'($urandom);
            drive(v, ins, op);
            if (v && rdy_m) begin
                for (int k = 0; k < 4; k++) expq.push_back(ref_nib(ins, op, k));
                accq.push_back({ins, op});
                nacc++;
            end
        end
        if (cyc >= 20000) begin
            n_vec++;
            n_err++;
            $display("FAIL rand timeout: accepted=%0d want 1000", nacc);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
